memory_access: RTL and testbench

Pipeline memory stage of the RV64 core. It sits between the execute/memory pipeline register and the memory/writeback register. It issues at most one data-bus transaction per instruction, stalls the pipeline until the bus returns `data_ok`, and performs store byte-lane alignment and load extraction with sign/zero extension. It produces `memory_data_t` for the downstream writeback stage, which selects `rd` when `wbSelect` is 2'b01.

---
 rtl/common.sv | 47 ++++
 rtl/memory_access.sv | 119 +++++++++++
 tb/tb_memory_access.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// Shared RV64 pipeline types: control bundle, stage payloads and data-bus request/response.
package common;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] wbSelect;
    logic       memRead;
    logic       memWrite;
    logic [1:0] msize;
    logic       memUnsigned;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] alu_out;
    logic [63:0] srcb;
    logic [4:0]  dst;
    logic [63:0] sextimm;
    control_t    ctl;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] alu_out;
    logic [63:0] sextimm;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] rd;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/memory_access.sv
// RV64 memory stage: one data-bus transaction per instruction, stalls until data_ok,
// aligns store lanes and extracts/extends load data.
module memory_access
  import common::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          hold_i,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stall_m,
  output logic          misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [63:0] rbuf, ld_raw, ld_val, rd_val;
  logic [2:0]  off;
  logic [5:0]  sh;
  logic [7:0]  strb_base;
  logic        mem_op, aligned, req, done, ld_ok;
  logic        unused;

  assign unused = dresp.addr_ok;

  assign off    = dataE.alu_out[2:0];
  assign sh     = {off, 3'b000};
  assign mem_op = dataE.valid & (dataE.ctl.memRead | dataE.ctl.memWrite);

  always_comb begin
    aligned   = 1'b1;
    strb_base = 8'h01;
    case (dataE.ctl.msize)
      2'b00:   begin aligned = 1'b1;             strb_base = 8'h01; end
      2'b01:   begin aligned = ~off[0];          strb_base = 8'h03; end
      2'b10:   begin aligned = (off[1:0] == 2'b00); strb_base = 8'h0F; end
      default: begin aligned = (off == 3'b000);  strb_base = 8'hFF; end
    endcase
  end

  // DONE blocks re-issue while the completed result waits out a downstream hold
  assign req  = ~reset & mem_op & aligned & (state != DONE);
  assign done = req & dresp.data_ok;

  always_comb begin
    dreq.valid  = req;
    dreq.addr   = dataE.alu_out;
    dreq.size   = {1'b0, dataE.ctl.msize};
    dreq.strobe = dataE.ctl.memWrite ? 8'(strb_base << off) : 8'h00;
    dreq.data   = dataE.ctl.memWrite ? (dataE.srcb << sh) : 64'h0;
  end

  assign ld_raw = dresp.data >> sh;

  always_comb begin
    ld_val = 64'h0;
    case (dataE.ctl.msize)
      2'b00:   ld_val = dataE.ctl.memUnsigned ? {56'h0, ld_raw[7:0]}
                                              : {{56{ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_val = dataE.ctl.memUnsigned ? {48'h0, ld_raw[15:0]}
                                              : {{48{ld_raw[15]}}, ld_raw[15:0]};
      2'b10:   ld_val = dataE.ctl.memUnsigned ? {32'h0, ld_raw[31:0]}
                                              : {{32{ld_raw[31]}}, ld_raw[31:0]};
      default: ld_val = ld_raw;
    endcase
  end

  assign ld_ok = ~reset & mem_op & aligned & dataE.ctl.memRead;

  always_comb begin
    rd_val = 64'h0;
    if (ld_ok) begin
      if (state == DONE)       rd_val = rbuf;
      else if (dresp.data_ok)  rd_val = ld_val;
    end
  end

  assign stall_m    = req & ~dresp.data_ok;
  assign misalign_o = ~reset & mem_op & ~aligned;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WAIT: begin
        if (!req)                state_nxt = IDLE;
        else if (!dresp.data_ok) state_nxt = WAIT;
        else                     state_nxt = hold_i ? DONE : IDLE;
      end
      DONE:    if (!hold_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rbuf  <= 64'h0;
    end else begin
      state <= state_nxt;
      if (done) rbuf <= dataE.ctl.memRead ? ld_val : 64'h0;
    end
  end

  always_comb begin
    dataM.valid   = dataE.valid;
    dataM.pc      = dataE.pc;
    dataM.alu_out = dataE.alu_out;
    dataM.sextimm = dataE.sextimm;
    dataM.ctl     = dataE.ctl;
    dataM.dst     = dataE.dst;
    dataM.rd      = rd_val;
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: scoreboard of expected load results plus direct bus checks.
module tb_memory_access;
  import common::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hold_i = 1'b0;
  execute_data_t dataE;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          stall_m, misalign_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_cnt;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .reset(reset), .dataE(dataE), .hold_i(hold_i),
    .dreq(dreq), .dresp(dresp), .dataM(dataM),
    .stall_m(stall_m), .misalign_o(misalign_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] addr, input logic [63:0] srcb);
    dataE                 = '0;
    dataE.valid           = 1'b1;
    dataE.pc              = 64'h8000_0000 + addr;
    dataE.alu_out         = addr;
    dataE.srcb            = srcb;
    dataE.dst             = 5'd7;
    dataE.sextimm         = 64'h10;
    dataE.ctl.regWrite    = ld;
    dataE.ctl.wbSelect    = ld ? 2'b01 : 2'b00;
    dataE.ctl.memRead     = ld;
    dataE.ctl.memWrite    = st;
    dataE.ctl.msize       = sz;
    dataE.ctl.memUnsigned = uns;
  endtask

  task automatic bus(input logic ok, input logic [63:0] d);
    dresp.addr_ok = 1'b1;
    dresp.data_ok = ok;
    dresp.data    = d;
  endtask

  // Scoreboard: every accepted transaction's rd is compared in its data_ok cycle
  always @(negedge clk) begin
    if (!reset && dreq.valid && dresp.data_ok) begin
      if (exp_q.size() == 0) check("sb_unexpected", 64'd1, 64'd0);
      else                   check("sb_rd", dataM.rd, exp_q.pop_front());
    end
  end

  initial begin
    dataE = '0;
    dresp = '0;

    // Reset with a live load presented
    @(posedge clk); #1;
    drive_op(1, 0, 2'b10, 0, 64'h1000, 0);
    bus(1, 64'hFFFF);
    @(negedge clk);
    check("rst_dreq_valid", dreq.valid, 0);
    check("rst_stall", stall_m, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_rd", dataM.rd, 0);
    check("rst_valid_pass", dataM.valid, 1);

    @(posedge clk); #1;
    reset = 1'b0; dataE = '0; bus(0, 0);
    @(negedge clk);
    check("idle_dreq_valid", dreq.valid, 0);

    // LB, offset 3, immediate data_ok
    @(posedge clk); #1;
    drive_op(1, 0, 2'b00, 0, 64'h1003, 0);
    bus(1, 64'h8877_6655_4433_2211);
    exp_q.push_back(64'h44);
    @(negedge clk);
    check("lb3_valid", dreq.valid, 1);
    check("lb3_stall", stall_m, 0);
    check("lb3_strobe", dreq.strobe, 8'h00);
    check("lb3_addr", dreq.addr, 64'h1003);
    check("lb3_size", dreq.size, 3'd0);

    // LB, offset 7, negative byte
    @(posedge clk); #1;
    drive_op(1, 0, 2'b00, 0, 64'h1007, 0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FF88);
    @(negedge clk);
    check("lb7_stall", stall_m, 0);
    check("lb7_pc_pass", dataM.pc, 64'h8000_1007);

    // SH to 0x2006
    @(posedge clk); #1;
    drive_op(0, 1, 2'b01, 0, 64'h2006, 64'hBEEF);
    bus(1, 0);
    exp_q.push_back(64'h0);
    @(negedge clk);
    check("sh_strobe", dreq.strobe, 8'hC0);
    check("sh_data", dreq.data, 64'hBEEF_0000_0000_0000);
    check("sh_size", dreq.size, 3'd1);
    check("sh_stall", stall_m, 0);

    // LW with three wait cycles
    @(posedge clk); #1;
    drive_op(1, 0, 2'b10, 0, 64'h3004, 0);
    bus(0, 64'hCAFE_BABE_0000_0000);
    exp_q.push_back(64'hFFFF_FFFF_CAFE_BABE);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lw_wait_valid", dreq.valid, 1);
      check("lw_wait_addr", dreq.addr, 64'h3004);
      check("lw_wait_size", dreq.size, 3'd2);
      check("lw_wait_strobe", dreq.strobe, 8'h00);
      if (stall_m) stall_cnt++;
      @(posedge clk); #1;
    end
    bus(1, 64'hCAFE_BABE_0000_0000);
    @(negedge clk);
    check("lw_done_stall", stall_m, 0);
    check("lw_done_valid", dreq.valid, 1);
    check("lw_stall_cycles", stall_cnt, 3);

    // LD completing under a two-cycle hold
    @(posedge clk); #1;
    drive_op(1, 0, 2'b11, 0, 64'h4008, 0);
    bus(1, 64'h0123_4567_89AB_CDEF);
    hold_i = 1'b1;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    check("ld_stall", stall_m, 0);
    @(posedge clk); #1;
    bus(0, 64'hDEAD_DEAD_DEAD_DEAD);
    @(negedge clk);
    check("ld_done_valid", dreq.valid, 0);
    check("ld_done_stall", stall_m, 0);
    check("ld_done_rd", dataM.rd, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;
    hold_i = 1'b0;
    bus(1, 64'hDEAD_DEAD_DEAD_DEAD);
    @(negedge clk);
    check("ld_release_valid", dreq.valid, 0);
    check("ld_release_rd", dataM.rd, 64'h0123_4567_89AB_CDEF);
    // Back in IDLE: a fresh request issues immediately
    @(posedge clk); #1;
    drive_op(1, 0, 2'b11, 0, 64'h4010, 0);
    bus(1, 64'h5555_AAAA_5555_AAAA);
    exp_q.push_back(64'h5555_AAAA_5555_AAAA);
    @(negedge clk);
    check("ld_next_valid", dreq.valid, 1);

    // Misaligned LW
    @(posedge clk); #1;
    drive_op(1, 0, 2'b10, 0, 64'h1002, 0);
    bus(0, 64'h1111_2222_3333_4444);
    @(negedge clk);
    check("mis_flag", misalign_o, 1);
    check("mis_valid", dreq.valid, 0);
    check("mis_stall", stall_m, 0);
    check("mis_rd", dataM.rd, 0);

    // Reset while waiting
    @(posedge clk); #1;
    drive_op(1, 0, 2'b10, 0, 64'h5000, 0);
    bus(0, 0);
    @(negedge clk);
    check("rw_stall", stall_m, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rw_rst_valid", dreq.valid, 0);
    check("rw_rst_stall", stall_m, 0);
    @(posedge clk); #1;
    reset = 1'b0; dataE = '0;
    bus(1, 64'h1234);
    @(negedge clk);
    check("stray_valid", dreq.valid, 0);
    check("stray_rd", dataM.rd, 0);

    // LWU after reset
    @(posedge clk); #1;
    drive_op(1, 0, 2'b10, 1, 64'h10, 0);
    bus(1, 64'hFFFF_FFFF_8000_0000);
    exp_q.push_back(64'h0000_0000_8000_0000);
    @(negedge clk);
    check("lwu_valid", dreq.valid, 1);
    check("lwu_stall", stall_m, 0);

    @(posedge clk); #1;
    dataE = '0; bus(0, 0);
    @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
